// File: rtl/uart_pkg.sv
// uart_pkg: receiver state encoding and default frame geometry for uart_rx.
package uart_pkg;
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
  localparam int CLKS_PER_BIT_DEF = 16;
  localparam int DATA_BITS_DEF = 8;
endpackage

// File: rtl/sync_2ff.sv
// sync_2ff: two-flop synchronizer for one asynchronous bit, with selectable reset value.
module sync_2ff #(
  parameter logic RST_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);
  logic s1;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) {q, s1} <= {RST_VAL, RST_VAL};
    else {q, s1} <= {s1, d};
endmodule

// File: rtl/uart_rx.sv
// uart_rx: mid-bit sampling UART receiver with a one-entry holding register.
// Optional even parity bit enabled by defining UART_RX_PARITY_EN.
module uart_rx
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEF,
  parameter int DATA_BITS = DATA_BITS_DEF
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 rx_i,
  output logic [DATA_BITS-1:0] data_o,
  output logic                 valid_o,
  input  logic                 ready_i,
  output logic                 frame_err_o,
`ifdef UART_RX_PARITY_EN
  output logic                 parity_err_o,
`endif
  output logic                 overrun_o
);
  localparam int TW = $clog2(CLKS_PER_BIT);
  localparam int BW = $clog2(DATA_BITS + 1);
  localparam logic [TW-1:0] T_HALF = TW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [TW-1:0] T_FULL = TW'(CLKS_PER_BIT - 1);
  logic                 rxs;
  state_t               state;
  logic [TW-1:0]        timer;
  logic [BW-1:0]        bitcnt;
  logic [DATA_BITS-1:0] shreg;
  logic                 tick;
`ifdef UART_RX_PARITY_EN
  logic                 par_bad;
`endif
  sync_2ff #(.RST_VAL(1'b1)) u_sync (.clk(clk), .rst_n(rst_n), .d(rx_i), .q(rxs));
  assign tick = timer == T_FULL;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state       <= IDLE;
      timer       <= '0;
      bitcnt      <= '0;
      shreg       <= '0;
      data_o      <= '0;
      valid_o     <= 1'b0;
      frame_err_o <= 1'b0;
      overrun_o   <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_bad      <= 1'b0;
      parity_err_o <= 1'b0;
`endif
    end else begin
      frame_err_o <= 1'b0;
      overrun_o   <= 1'b0;
`ifdef UART_RX_PARITY_EN
      parity_err_o <= 1'b0;
`endif
      if (valid_o && ready_i) valid_o <= 1'b0;
      case (state)
        IDLE: begin
          timer  <= '0;
          bitcnt <= '0;
          if (!rxs) state <= START;
        end
        START:
          if (timer == T_HALF) begin
            timer <= '0;
            state <= rxs ? IDLE : DATA;
          end else timer <= timer + 1'b1;
        DATA:
          if (tick) begin
            timer  <= '0;
            shreg  <= {rxs, shreg[DATA_BITS-1:1]};
            bitcnt <= bitcnt + 1'b1;
`ifdef UART_RX_PARITY_EN
            if (bitcnt == BW'(DATA_BITS - 1)) state <= PARITY;
`else
            if (bitcnt == BW'(DATA_BITS - 1)) state <= STOP;
`endif
          end else timer <= timer + 1'b1;
`ifdef UART_RX_PARITY_EN
        PARITY:
          if (tick) begin
            timer   <= '0;
            par_bad <= rxs ^ (^shreg);
            state   <= STOP;
          end else timer <= timer + 1'b1;
`endif
        STOP:
          if (tick) begin
            timer <= '0;
            state <= IDLE;
            // a handshake in this same cycle frees the holding register for the new byte
            if (!rxs) frame_err_o <= 1'b1;
`ifdef UART_RX_PARITY_EN
            else if (par_bad) parity_err_o <= 1'b1;
`endif
            else if (!valid_o || ready_i) begin
              data_o  <= shreg;
              valid_o <= 1'b1;
            end else overrun_o <= 1'b1;
          end else timer <= timer + 1'b1;
        default: state <= IDLE;
      endcase
    end
endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: scoreboard bench for uart_rx; expected bytes are queued as frames are sent.
module tb_uart_rx;
  import uart_pkg::*;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       rx = 1'b1;
  logic       ready = 1'b1;
  logic [7:0] data;
  logic       valid, ferr, ovr;
`ifdef UART_RX_PARITY_EN
  logic       perr;
  int         perr_cnt = 0;
  localparam int LAT_EXTRA = 16;
`else
  localparam int LAT_EXTRA = 0;
`endif
  int         checks = 0, failures = 0;
  int         ferr_cnt = 0, ovr_cnt = 0, vcnt = 0, lat = 0, snap;
  logic [7:0] q[$];

  uart_rx dut (
    .clk(clk), .rst_n(rst_n), .rx_i(rx), .data_o(data), .valid_o(valid),
    .ready_i(ready), .frame_err_o(ferr),
`ifdef UART_RX_PARITY_EN
    .parity_err_o(perr),
`endif
    .overrun_o(ovr)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
    end
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop, input logic pflip);
    rx = 1'b0;
    repeat (16) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx = d[i];
      repeat (16) @(negedge clk);
    end
`ifdef UART_RX_PARITY_EN
    rx = (^d) ^ pflip;
    repeat (16) @(negedge clk);
`else
    if (pflip) rx = 1'b1;
`endif
    rx = stop;
    repeat (16) @(negedge clk);
    rx = 1'b1;
    repeat (24) @(negedge clk);
  endtask

  always @(negedge clk) begin
    #1;
    if (rst_n) begin
      if (valid && ready) begin
        if (q.size() == 0) chk("unexpected_byte", {24'd0, data}, 32'hFFFF_FFFF);
        else chk("data", {24'd0, data}, {24'd0, q.pop_front()});
      end
      vcnt     += int'(valid);
      ferr_cnt += int'(ferr);
      ovr_cnt  += int'(ovr);
`ifdef UART_RX_PARITY_EN
      perr_cnt += int'(perr);
`endif
    end
  end

  initial begin
    #1;
    chk("rst_valid", valid, 0);
    chk("rst_data", data, 0);
    chk("rst_ferr", ferr, 0);
    chk("rst_ovr", ovr, 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    // basic frame, measuring start-edge to valid latency
    q.push_back(8'hA5);
    snap = vcnt;
    fork
      send_frame(8'hA5, 1'b1, 1'b0);
      begin
        lat = 0;
        do begin
          @(negedge clk);
          lat++;
        end while (!valid && lat < 400);
      end
    join
    chk("latency_range", (lat >= 150 + LAT_EXTRA && lat <= 170 + LAT_EXTRA), 1);
    chk("valid_one_cycle", vcnt - snap, 1);
    chk("no_ferr", ferr_cnt, 0);
    chk("no_ovr", ovr_cnt, 0);
    // false start
    rx = 1'b0;
    repeat (5) @(negedge clk);
    rx = 1'b1;
    repeat (20) @(negedge clk);
    chk("false_start_idle", dut.state, IDLE);
    chk("false_start_novalid", valid, 0);
    q.push_back(8'h3C);
    send_frame(8'h3C, 1'b1, 1'b0);
    // framing error
    snap = vcnt;
    send_frame(8'h55, 1'b0, 1'b0);
    chk("ferr_pulse", ferr_cnt, 1);
    chk("ferr_novalid", vcnt - snap, 0);
    // overrun
    ready = 1'b0;
    q.push_back(8'h11);
    send_frame(8'h11, 1'b1, 1'b0);
    send_frame(8'h22, 1'b1, 1'b0);
    chk("ovr_pulse", ovr_cnt, 1);
    chk("ovr_held_valid", valid, 1);
    chk("ovr_held_data", data, 8'h11);
    ready = 1'b1;
    repeat (2) @(negedge clk);
    chk("ovr_drain", valid, 0);
    // handshake coincident with completion
    ready = 1'b0;
    q.push_back(8'h66);
    send_frame(8'h66, 1'b1, 1'b0);
    q.push_back(8'h77);
    snap = ovr_cnt;
    fork
      send_frame(8'h77, 1'b1, 1'b0);
      begin
        repeat (lat - 1) @(negedge clk);
        ready = 1'b1;
        @(negedge clk);
        ready = 1'b0;
        #2;
        chk("same_cycle_valid", valid, 1);
        chk("same_cycle_data", data, 8'h77);
      end
    join
    chk("same_cycle_no_ovr", ovr_cnt - snap, 0);
    ready = 1'b1;
    repeat (2) @(negedge clk);
    chk("same_cycle_drain", valid, 0);
    // reset during DATA with a byte held
    ready = 1'b0;
    q.push_back(8'h5A);
    send_frame(8'h5A, 1'b1, 1'b0);
    chk("pre_rst_valid", valid, 1);
    rx = 1'b0;
    repeat (16) @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      rx = i[0];
      repeat (16) @(negedge clk);
    end
    chk("pre_rst_in_data", dut.state, DATA);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", valid, 0);
    chk("mid_rst_data", data, 0);
    chk("mid_rst_state", dut.state, IDLE);
    q.delete();
    rx = 1'b1;
    ready = 1'b1;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    q.push_back(8'h0F);
    send_frame(8'h0F, 1'b1, 1'b0);
`ifdef UART_RX_PARITY_EN
    snap = vcnt;
    send_frame(8'h07, 1'b1, 1'b1);
    chk("parity_err_pulse", perr_cnt, 1);
    chk("parity_discard", vcnt - snap, 0);
`endif
    chk("queue_empty", q.size(), 0);
    chk("final_ferr", ferr_cnt, 1);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
